// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: IDLE -> ACCESS (-> RDATA) with registered outputs.
// Tie-break policy: fixed priority to requester 0 by default, round-robin when RAM_ARB_RR_EN is defined.
module ram_arbiter #(
    parameter int DW = 72,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_0,
    input  logic          req_1,
    input  logic          wr_0,
    input  logic          wr_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_0,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata_0,
    output logic [DW-1:0] rdata_1,
    output logic          ram_enb,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_r_data,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t        r_state, w_state_n;
    logic          r_gnt_0, r_gnt_1, r_rvalid_0, r_rvalid_1;
    logic          r_ram_enb, r_ram_wr, r_busy, r_owner;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_data, r_rdata_0, r_rdata_1;

    logic          w_gnt_0, w_gnt_1, w_rvalid_0, w_rvalid_1;
    logic          w_ram_enb, w_ram_wr, w_owner;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_data, w_rdata_0, w_rdata_1;
    logic          w_req_any, w_win;

    assign w_req_any = req_0 | req_1;

`ifdef RAM_ARB_RR_EN
    // r_last starts at 1 so the first tie after reset goes to requester 0.
    logic r_last;
    assign w_win = (req_0 && req_1) ? ~r_last : req_1;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (r_state == IDLE && w_req_any)
            r_last <= w_win;
    end
`else
    assign w_win = ~req_0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (w_req_any) w_state_n = ACCESS;
            ACCESS:  w_state_n = r_ram_wr ? IDLE : RDATA;
            RDATA:   w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs; the access is latched straight into the RAM-side registers.
    always_comb begin
        w_gnt_0    = 1'b0;
        w_gnt_1    = 1'b0;
        w_rvalid_0 = 1'b0;
        w_rvalid_1 = 1'b0;
        w_ram_enb  = 1'b0;
        w_ram_wr   = 1'b0;
        w_ram_addr = r_ram_addr;
        w_ram_data = r_ram_data;
        w_rdata_0  = r_rdata_0;
        w_rdata_1  = r_rdata_1;
        w_owner    = r_owner;
        case (r_state)
            IDLE: begin
                if (w_req_any) begin
                    w_owner    = w_win;
                    w_gnt_0    = ~w_win;
                    w_gnt_1    = w_win;
                    w_ram_enb  = 1'b1;
                    w_ram_wr   = w_win ? wr_1    : wr_0;
                    w_ram_addr = w_win ? addr_1  : addr_0;
                    w_ram_data = w_win ? wdata_1 : wdata_0;
                end
            end
            RDATA: begin
                if (r_owner) begin
                    w_rdata_1  = ram_r_data;
                    w_rvalid_1 = 1'b1;
                end else begin
                    w_rdata_0  = ram_r_data;
                    w_rvalid_0 = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_0    <= 1'b0;
            r_gnt_1    <= 1'b0;
            r_rvalid_0 <= 1'b0;
            r_rvalid_1 <= 1'b0;
            r_ram_enb  <= 1'b0;
            r_ram_wr   <= 1'b0;
            r_busy     <= 1'b0;
            r_owner    <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_rdata_0  <= '0;
            r_rdata_1  <= '0;
        end else begin
            r_gnt_0    <= w_gnt_0;
            r_gnt_1    <= w_gnt_1;
            r_rvalid_0 <= w_rvalid_0;
            r_rvalid_1 <= w_rvalid_1;
            r_ram_enb  <= w_ram_enb;
            r_ram_wr   <= w_ram_wr;
            r_busy     <= (w_state_n != IDLE);
            r_owner    <= w_owner;
            r_ram_addr <= w_ram_addr;
            r_ram_data <= w_ram_data;
            r_rdata_0  <= w_rdata_0;
            r_rdata_1  <= w_rdata_1;
        end
    end

    assign gnt_0    = r_gnt_0;
    assign gnt_1    = r_gnt_1;
    assign rvalid_0 = r_rvalid_0;
    assign rvalid_1 = r_rvalid_1;
    assign rdata_0  = r_rdata_0;
    assign rdata_1  = r_rdata_1;
    assign ram_enb  = r_ram_enb;
    assign ram_wr   = r_ram_wr;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign busy     = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small registered-read RAM model on the RAM port.
module tb_ram_arbiter;
    localparam int DW = 72;
    localparam int AW = 2;
    localparam logic [DW-1:0] WV = 72'hAB_CDEF_0123_4567_89AB;
    localparam logic [DW-1:0] D1 = 72'h11_2222_3333_4444_5555;
    localparam logic [DW-1:0] D2 = 72'h66_7777_8888_9999_AAAA;

    logic          clk = 1'b0;
    logic          rst, req_0, req_1, wr_0, wr_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          ram_enb, ram_wr, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_r_data;

    logic [DW-1:0] mem [4];
    int n_tests = 0;
    int n_fail  = 0;

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .wr_0(wr_0), .wr_1(wr_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .ram_enb(ram_enb), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_r_data(ram_r_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: write on enb&&wr, read data registered on the edge ending an enb&&!wr cycle.
    always @(posedge clk) begin
        if (ram_enb) begin
            if (ram_wr) mem[ram_addr] <= ram_data;
            else        ram_r_data    <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_w;
        rst = 1'b1; req_0 = 0; req_1 = 0; wr_0 = 0; wr_1 = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        tick(); tick();
        chk("rst_gnt0", gnt_0, 0);      chk("rst_gnt1", gnt_1, 0);
        chk("rst_rv0", rvalid_0, 0);    chk("rst_rv1", rvalid_1, 0);
        chk("rst_enb", ram_enb, 0);     chk("rst_wr", ram_wr, 0);
        chk("rst_busy", busy, 0);       chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);   chk("rst_rd0", rdata_0, 0);
        chk("rst_rd1", rdata_1, 0);
        rst = 1'b0;
        tick();

        // Write 3 <- WV by requester 0
        req_0 = 1; wr_0 = 1; addr_0 = 2'd3; wdata_0 = WV;
        tick();
        chk("wr_gnt0", gnt_0, 1);  chk("wr_gnt1", gnt_1, 0);
        chk("wr_enb", ram_enb, 1); chk("wr_wr", ram_wr, 1);
        chk("wr_addr", ram_addr, 3); chk("wr_data", ram_data, WV);
        chk("wr_busy", busy, 1);
        req_0 = 0; wr_0 = 0;
        tick();
        chk("wr_end_enb", ram_enb, 0); chk("wr_end_wr", ram_wr, 0);
        chk("wr_end_busy", busy, 0);   chk("wr_end_gnt0", gnt_0, 0);
        chk("wr_hold_addr", ram_addr, 3); chk("wr_hold_data", ram_data, WV);

        // Read 3 by requester 1, re-arbitrated in the IDLE cycle after the write
        req_1 = 1; wr_1 = 0; addr_1 = 2'd3;
        tick();
        chk("rd_gnt1", gnt_1, 1); chk("rd_gnt0", gnt_0, 0);
        chk("rd_enb", ram_enb, 1); chk("rd_wr", ram_wr, 0); chk("rd_addr", ram_addr, 3);
        req_1 = 0;
        tick();
        chk("rd_rdata_enb", ram_enb, 0); chk("rd_rdata_busy", busy, 1);
        chk("rd_rdata_rv1", rvalid_1, 0);
        tick();
        chk("rd_rv1", rvalid_1, 1); chk("rd_rv0", rvalid_0, 0);
        chk("rd_rd1", rdata_1, WV); chk("rd_busy", busy, 0);
        tick();
        chk("rd_rv1_pulse", rvalid_1, 0); chk("rd_rd1_hold", rdata_1, WV);

        // Tie: both reads held for four arbitrations
        req_0 = 1; req_1 = 1; wr_0 = 0; wr_1 = 0; addr_0 = 2'd3; addr_1 = 2'd3;
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
            exp_w = k[0];
`else
            exp_w = 1'b0;
`endif
            tick();
            chk("tie_gnt0", gnt_0, !exp_w);
            chk("tie_gnt1", gnt_1, exp_w);
            chk("tie_no_overlap", gnt_0 & gnt_1, 0);
            tick();
            tick();
            chk("tie_rv0", rvalid_0, !exp_w);
            chk("tie_rv1", rvalid_1, exp_w);
            if (k == 3) begin req_0 = 0; req_1 = 0; end
        end
        tick();
        chk("tie_idle_busy", busy, 0);

        // Busy blocking: req_1 raised in the ACCESS cycle of a read by 0
        req_0 = 1; addr_0 = 2'd3;
        tick();
        chk("blk_gnt0", gnt_0, 1);
        req_0 = 0; req_1 = 1; addr_1 = 2'd3;
        chk("blk_busy_acc", busy, 1);
        tick();
        chk("blk_gnt1_rdata", gnt_1, 0); chk("blk_busy_rdata", busy, 1);
        tick();
        chk("blk_gnt1_idle", gnt_1, 0); chk("blk_rv0", rvalid_0, 1);
        chk("blk_rd0", rdata_0, WV);
        tick();
        chk("blk_gnt1", gnt_1, 1); chk("blk_busy_g1", busy, 1);
        req_1 = 0;
        tick(); tick();
        chk("blk_rv1", rvalid_1, 1);

        // Reset mid-read
        req_0 = 1; addr_0 = 2'd3;
        tick();
        chk("mr_gnt0", gnt_0, 1);
        req_0 = 0;
        tick();
        rst = 1;
        tick();
        chk("mr_rv0", rvalid_0, 0); chk("mr_enb", ram_enb, 0);
        chk("mr_busy", busy, 0);    chk("mr_rd0", rdata_0, 0);
        chk("mr_addr", ram_addr, 0);
        rst = 0;
        tick();
        chk("mr_rv0_after", rvalid_0, 0); chk("mr_gnt0_after", gnt_0, 0);
        chk("mr_busy_after", busy, 0);

        // First tie after reset goes to 0; writes re-arbitrate right after 2 cycles
        req_0 = 1; req_1 = 1; wr_0 = 1; wr_1 = 1;
        addr_0 = 2'd1; addr_1 = 2'd2; wdata_0 = D1; wdata_1 = D2;
        tick();
        chk("ft_gnt0", gnt_0, 1); chk("ft_gnt1", gnt_1, 0);
        chk("ft_addr", ram_addr, 1); chk("ft_data", ram_data, D1);
        req_0 = 0;
        tick();
        chk("ft_idle_enb", ram_enb, 0);
        tick();
        chk("ft2_gnt1", gnt_1, 1); chk("ft2_addr", ram_addr, 2);
        chk("ft2_data", ram_data, D2); chk("ft2_wr", ram_wr, 1);
        req_1 = 0;
        tick();
        chk("ft_end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
